// File: rtl/xheep_load_pkg.sv
// Shared types and defaults for the X-HEEP program-load sequencer.
package xheep_load_pkg;

  typedef enum logic [1:0] {
    OP_NOP      = 2'd0,
    OP_SET_ADDR = 2'd1,
    OP_WRITE    = 2'd2,
    OP_CLR      = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ADDR_WAIT = 2'd1,
    S_DATA_WAIT = 2'd2,
    S_ERR       = 2'd3
  } seq_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/xheep_load_sequencer.sv
// Host-side sequencer driving the bridge2xheep address/instruction valid flags.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no flag raised; accepts a command when the bridge is not busy
// ADDR_WAIT | new_addr_valid_o high, waiting for rst_new_addr_valid_i
// DATA_WAIT | inst_valid_o high, waiting for rst_instr_valid_i
// ERR       | a flag timed out; only CLR leaves, other commands are dropped
module xheep_load_sequencer
  import xheep_load_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [31:0]      cmd_data_i,
  output logic             new_addr_valid_o,
  output logic [31:0]      new_section_address_o,
  output logic             inst_valid_o,
  output logic [31:0]      instruction_o,
  input  logic             busy_i,
  input  logic             rst_new_addr_valid_i,
  input  logic             rst_instr_valid_i,
  input  logic             obi_rvalid_i,
  input  logic [31:0]      obi_rdata_i,
  output logic [CNT_W-1:0] words_written_o,
  output logic [31:0]      checksum_o,
  output logic [31:0]      last_rdata_o,
  output logic             err_timeout_o,
  output logic             idle_o
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [31:0]      csum_q, csum_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q;
  logic             hs;
  cmd_op_e          op;

  assign op          = cmd_op_e'(cmd_op_i);
  assign cmd_ready_o = ((state_q == S_IDLE) && !busy_i) || (state_q == S_ERR);
  assign hs          = cmd_valid_i && cmd_ready_o;

  // The bridge flags are pure functions of the wait states, so leaving a
  // wait state (ack, timeout or reset) drops the flag on the same edge.
  assign new_addr_valid_o      = (state_q == S_ADDR_WAIT);
  assign inst_valid_o          = (state_q == S_DATA_WAIT);
  assign new_section_address_o = addr_q;
  assign instruction_o         = instr_q;
  assign words_written_o       = words_q;
  assign checksum_o            = csum_q;
  assign last_rdata_o          = rdata_q;
  assign err_timeout_o         = err_q;
  assign idle_o                = (state_q == S_IDLE) && !busy_i;

  // State, timer and statistics registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      words_q <= '0;
      csum_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      words_q <= words_d;
      csum_q  <= csum_d;
      err_q   <= err_d;
    end
  end

  // OBI read-data capture runs regardless of the sequencer state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (obi_rvalid_i) begin
      rdata_q <= obi_rdata_i;
    end
  end

  // Next-state logic: command acceptance, ack tracking and timeout.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    words_d = words_q;
    csum_d  = csum_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          case (op)
            OP_SET_ADDR: begin
              addr_d  = cmd_data_i;
              words_d = '0;
              csum_d  = '0;
              timer_d = '0;
              state_d = S_ADDR_WAIT;
            end
            OP_WRITE: begin
              instr_d = cmd_data_i;
              timer_d = '0;
              state_d = S_DATA_WAIT;
            end
            OP_CLR:  err_d = 1'b0;
            default: ;
          endcase
        end
      end
      S_ADDR_WAIT: begin
        // An ack on the expiry cycle still counts as normal completion.
        if (rst_new_addr_valid_i) begin
          state_d = S_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DATA_WAIT: begin
        if (rst_instr_valid_i) begin
          words_d = words_q + CNT_W'(1);
          csum_d  = csum_q ^ instr_q;
          state_d = S_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_ERR: begin
        if (hs && (op == OP_CLR)) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_xheep_load_sequencer.sv
// Directed bench for xheep_load_sequencer: a transaction table plus
// hand-written sequences for busy back-pressure, timeout, and reset.
module tb_xheep_load_sequencer;

  localparam int unsigned TO    = 16;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] NOP = 2'd0, SETA = 2'd1, WR = 2'd2, CLR = 2'd3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_data;
  logic             nav;
  logic [31:0]      nsa;
  logic             iv;
  logic [31:0]      instr;
  logic             busy;
  logic             ack_a;
  logic             ack_i;
  logic             rvalid;
  logic [31:0]      rdata;
  logic [CNT_W-1:0] words;
  logic [31:0]      csum;
  logic [31:0]      last_rd;
  logic             err;
  logic             idle;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xheep_load_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .cmd_valid_i           (cmd_valid),
    .cmd_ready_o           (cmd_ready),
    .cmd_op_i              (cmd_op),
    .cmd_data_i            (cmd_data),
    .new_addr_valid_o      (nav),
    .new_section_address_o (nsa),
    .inst_valid_o          (iv),
    .instruction_o         (instr),
    .busy_i                (busy),
    .rst_new_addr_valid_i  (ack_a),
    .rst_instr_valid_i     (ack_i),
    .obi_rvalid_i          (rvalid),
    .obi_rdata_i           (rdata),
    .words_written_o       (words),
    .checksum_o            (csum),
    .last_rdata_o          (last_rd),
    .err_timeout_o         (err),
    .idle_o                (idle)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    int          hold;      // cycles the flag stays high before ack drops it
    logic [15:0] exp_words;
    logic [31:0] exp_csum;
  } txn_t;

  txn_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for ready, complete the handshake.
  task automatic send(input logic [1:0] op, input logic [31:0] data);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    #1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check("ready_wait", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    cmd_op    = NOP;
  endtask

  task automatic run_txn(input txn_t t);
    send(t.op, t.data);
    for (int k = 0; k < t.hold; k++) begin
      if (t.op == SETA) begin
        check("addr_valid_hi", {31'd0, nav}, 32'd1);
        check("inst_valid_lo", {31'd0, iv}, 32'd0);
        check("addr_stable", nsa, t.data);
        if (k == t.hold - 1) ack_a = 1'b1;
      end else begin
        check("inst_valid_hi", {31'd0, iv}, 32'd1);
        check("addr_valid_lo", {31'd0, nav}, 32'd0);
        check("instr_stable", instr, t.data);
        if (k == t.hold - 1) ack_i = 1'b1;
      end
      step();
      ack_a = 1'b0;
      ack_i = 1'b0;
    end
    check("flags_low", {30'd0, nav, iv}, 32'd0);
    check("ready_after", {31'd0, cmd_ready}, 32'd1);
    check("words", {16'd0, words}, {16'd0, t.exp_words});
    check("csum", csum, t.exp_csum);
    check("err_clear", {31'd0, err}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{SETA, 32'h0000_0180, 3, 16'd0, 32'h0000_0000};
    tbl[1] = '{WR,   32'h0000_0013, 1, 16'd1, 32'h0000_0013};
    tbl[2] = '{WR,   32'h0010_0093, 2, 16'd2, 32'h0010_0080};
    tbl[3] = '{WR,   32'hDEAD_BEEF, 4, 16'd3, 32'hDEBD_BE6F};
    tbl[4] = '{SETA, 32'h0000_2000, 1, 16'd0, 32'h0000_0000};
    tbl[5] = '{WR,   32'h0000_0001, 1, 16'd1, 32'h0000_0001};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_data = '0;
    busy = 1'b0; ack_a = 1'b0; ack_i = 1'b0; rvalid = 1'b0; rdata = '0;
    step(); step();
    rst_n = 1'b1;
    #1;
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_flags", {30'd0, nav, iv}, 32'd0);
    check("rst_words", {16'd0, words}, 32'd0);
    check("rst_csum", csum, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_rdata", last_rd, 32'd0);

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);
    check("addr_kept", nsa, 32'h0000_2000);

    // Busy back-pressure with a pending WRITE.
    busy = 1'b1; cmd_valid = 1'b1; cmd_op = WR; cmd_data = 32'h0000_0055;
    #1;
    for (int k = 0; k < 10; k++) begin
      check("busy_ready_lo", {31'd0, cmd_ready}, 32'd0);
      check("busy_no_flag", {30'd0, nav, iv}, 32'd0);
      check("busy_idle_lo", {31'd0, idle}, 32'd0);
      step();
    end
    busy = 1'b0;
    #1;
    check("unbusy_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    check("busy_wr_iv", {31'd0, iv}, 32'd1);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    check("busy_wr_done", {31'd0, iv}, 32'd0);
    check("busy_words", {16'd0, words}, 32'd2);
    check("busy_csum", csum, 32'h0000_0054);

    // Timeout: no ack for TO cycles.
    send(WR, 32'h0000_0077);
    for (int k = 0; k < int'(TO); k++) begin
      check("to_iv_hi", {31'd0, iv}, 32'd1);
      step();
    end
    check("to_iv_lo", {31'd0, iv}, 32'd0);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_words", {16'd0, words}, 32'd2);
    busy = 1'b1;
    #1;
    check("err_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = WR; cmd_data = 32'h0000_0099;
    step();
    check("err_wr_drop", {31'd0, iv}, 32'd0);
    check("err_still", {31'd0, err}, 32'd1);
    cmd_op = CLR;
    step();
    cmd_valid = 1'b0; cmd_op = NOP; busy = 1'b0;
    #1;
    check("clr_err", {31'd0, err}, 32'd0);
    check("clr_idle", {31'd0, idle}, 32'd1);
    check("clr_words", {16'd0, words}, 32'd2);

    // Ack on the expiry cycle wins; stray address ack is ignored.
    send(WR, 32'h0000_0100);
    for (int k = 0; k < int'(TO); k++) begin
      check("co_iv_hi", {31'd0, iv}, 32'd1);
      ack_a = (k == 5);
      ack_i = (k == int'(TO) - 1);
      step();
      ack_a = 1'b0;
      ack_i = 1'b0;
    end
    check("co_iv_lo", {31'd0, iv}, 32'd0);
    check("co_err", {31'd0, err}, 32'd0);
    check("co_words", {16'd0, words}, 32'd3);
    check("co_csum", csum, 32'h0000_0154);

    // OBI capture mid-WRITE, then reset in DATA_WAIT.
    send(WR, 32'h0000_0200);
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    step();
    rvalid = 1'b0; rdata = 32'h1234_5678;
    check("obi_cap", last_rd, 32'hCAFE_F00D);
    step();
    check("obi_hold", last_rd, 32'hCAFE_F00D);
    check("obi_iv", {31'd0, iv}, 32'd1);
    rst_n = 1'b0;
    step();
    check("mid_rst_flags", {30'd0, nav, iv}, 32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid_rst_words", {16'd0, words}, 32'd0);
    check("mid_rst_csum", csum, 32'd0);
    check("mid_rst_rdata", last_rd, 32'd0);
    check("mid_rst_instr", instr, 32'd0);
    check("mid_rst_addr", nsa, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
